adc_avg_sched: RTL and testbench
================================

Name: adc_avg_sched

Overview:
- Sits directly downstream of the AD7091R socket.
- Paces conversions by issuing a one-cycle `rd_en` request every PERIOD clocks.
- Consumes each `adc_rdy`/`adc_data` result and accumulates 2^LOG2_N samples.
- Emits a truncated mean with a one-cycle valid strobe to the host/register layer, and flags any request that gets no response within TIMEOUT clocks.

Parameters:
- PERIOD, 64: sample period in clk cycles; legal range 40..65535, since the socket needs about 38 cycles per conversion.
- LOG2_N, 4: log2 of samples per average; legal range 0..8.
- TIMEOUT, 48: maximum cycles from request to `adc_rdy_i`; legal range 40..255.

Ports:
- clk  in  1  system clock, same domain as the socket (≤13.56 MHz)
- rst_n  in  1  asynchronous active-low reset
- en  in  1  clock enable shared with the socket
- run  in  1  level; 1 = continuous sampling, 0 = stop
- rd_en_o  out  1  conversion request to the socket
- adc_data_i  in  12  sample from the socket
- adc_rdy_i  in  1  one-cycle sample-valid strobe from the socket
- avg_o  out  12  averaged sample
- avg_vld_o  out  1  one-cycle strobe; avg_o is valid in the same cycle
- busy_o  out  1  high in any state other than IDLE
- timeout_o  out  1  one-cycle strobe raised when a request goes unanswered

Behaviour:
- Reset:
  - All outputs are 0; FSM goes to IDLE.
  - Accumulator, sample counter, period counter and timeout counter are 0.
  - Reset mid-operation aborts immediately. No partial average is output.
- en gating:
  - When en=0, every register holds its value.
  - rd_en_o, avg_vld_o and timeout_o are forced to 0 in that cycle.
- One-hot states: IDLE, WAIT_TICK, REQ, WAIT_RDY, ACC, OUT.
- Period counter:
  - Cleared in IDLE.
  - Otherwise counts 0..PERIOD-1 and wraps; tick = (count == PERIOD-1).
  - Keeps running during WAIT_RDY, ACC and OUT, so the sample spacing is exactly PERIOD.
- IDLE → WAIT_TICK when run=1.
- WAIT_TICK:
  - run=0 → IDLE; the partial accumulation is discarded.
  - tick → REQ.
- REQ: registered rd_en_o=1 for exactly one cycle; timeout counter cleared; → WAIT_RDY.
- WAIT_RDY:
  - adc_rdy_i=1 → ACC. The sample is captured in that cycle: acc += adc_data_i; sample count += 1.
  - Timeout counter reaches TIMEOUT-1 without adc_rdy_i → timeout_o pulse; acc and sample count cleared; → WAIT_TICK.
  - run is ignored in this state. An in-flight conversion always completes.
  - Ticks arriving in this state are dropped; the socket is never re-requested while busy.
- ACC:
  - sample count == 2^LOG2_N → OUT.
  - Otherwise → WAIT_TICK.
- OUT:
  - avg_o ← acc[LOG2_N +: 12], i.e. truncation with no rounding.
  - avg_vld_o=1 for this cycle; acc and sample count cleared.
  - → WAIT_TICK if run=1, else → IDLE.
- Accumulator width is 12+LOG2_N, so it cannot overflow: max 4095·2^LOG2_N.
- avg_o holds its value until the next OUT.
- adc_rdy_i outside WAIT_RDY (a spurious strobe) is ignored.
- Latency: the first avg_vld_o occurs 2^LOG2_N·PERIOD + O(socket latency) cycles after run rises.

Optional Feature:
- Macro: ADC_AVG_MINMAX_EN.
- Defined:
  - Adds ports min_o [11:0] and max_o [11:0].
  - Tracks the running min and max of the samples in the current window.
  - Both are updated in the OUT cycle alongside avg_o and reset to 0.
  - Window trackers re-initialise on the first sample of each window: min=4095, max=0.
  - A timeout clears the trackers.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package adc_avg_pkg holds:
  - ADC_W = 12;
  - the one-hot state constants (6-bit) S_IDLE..S_OUT;
  - the state vector typedef.
- One sub-module: adc_tick_gen, the period counter.
  - Ports: clk, rst_n, en, clr, tick.
  - Parameter: PERIOD.

Test Plan (PERIOD=50, LOG2_N=2, TIMEOUT=48, socket model answers 38 cycles after rd_en):
- Samples 100, 200, 300, 401 → a single avg_vld_o with avg_o=250; rd_en_o pulses are exactly 50 cycles apart.
- Four samples of 4095 → avg_o=4095, with no overflow in the 14-bit accumulator.
- Model never answers the 2nd request → timeout_o pulses 48 cycles after that rd_en_o. The next window restarts: samples 8, 8, 8, 8 → avg_o=8, with no contamination from the 1st sample.
- run drops during WAIT_RDY of the 3rd sample → the sample is still absorbed, the FSM returns to IDLE at the next WAIT_TICK, no avg_vld_o is produced, and busy_o=0.
- Hold en=0 for 20 cycles mid-WAIT_RDY → all state is frozen and the strobes stay 0. After en=1, the average is unchanged versus the reference run, shifted 20 cycles.
- rst_n asserted in ACC → all outputs are 0 immediately. After release with run=1, the first rd_en_o comes 50 cycles after entering WAIT_TICK.

Source files
------------

// File: rtl/adc_avg_pkg.sv
// Shared definitions for the ADC averaging scheduler: sample width,
// one-hot sequencer states and small comparison helpers.
package adc_avg_pkg;

  localparam int ADC_W = 12;

  typedef enum logic [5:0] {
    S_IDLE      = 6'b000001,
    S_WAIT_TICK = 6'b000010,
    S_REQ       = 6'b000100,
    S_WAIT_RDY  = 6'b001000,
    S_ACC       = 6'b010000,
    S_OUT       = 6'b100000
  } state_t;

  function automatic logic [ADC_W-1:0] min_of(input logic [ADC_W-1:0] a,
                                               input logic [ADC_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [ADC_W-1:0] max_of(input logic [ADC_W-1:0] a,
                                               input logic [ADC_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Free-running sample-period counter; tick marks the last cycle of each period.
module adc_tick_gen #(
  parameter int PERIOD = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_r;

  // Period counter: cleared on request, otherwise wraps at PERIOD-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (en) begin
      if (clr || (cnt_r == LAST)) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/adc_avg_sched.sv
// Paces AD7091R conversions, averages 2^LOG2_N samples and flags lost replies.
// Build option ADC_AVG_MINMAX_EN adds per-window min_o/max_o outputs.
module adc_avg_sched
  import adc_avg_pkg::*;
#(
  parameter int PERIOD  = 64,
  parameter int LOG2_N  = 4,
  parameter int TIMEOUT = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             run,
  output logic             rd_en_o,
  input  logic [ADC_W-1:0] adc_data_i,
  input  logic             adc_rdy_i,
  output logic [ADC_W-1:0] avg_o,
  output logic             avg_vld_o,
  output logic             busy_o,
  output logic             timeout_o
`ifdef ADC_AVG_MINMAX_EN
  ,
  output logic [ADC_W-1:0] min_o,
  output logic [ADC_W-1:0] max_o
`endif
);

  localparam int ACC_W = ADC_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] N_SAMP = CNT_W'(2 ** LOG2_N);
  // Last waiting cycle: the strobe then lands TIMEOUT cycles after rd_en_o.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 2);

  state_t           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] smp_cnt_r;
  logic [7:0]       tmo_cnt_r;
  logic             rd_en_r;
  logic             avg_vld_r;
  logic             timeout_r;
  logic             tick_s;
  logic             tick_clr_s;

  assign tick_clr_s = (state_r == S_IDLE);

  adc_tick_gen #(
    .PERIOD(PERIOD)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (tick_clr_s),
    .tick (tick_s)
  );

  // Sequencer: request on tick, collect the reply, publish the window mean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      acc_r     <= '0;
      smp_cnt_r <= '0;
      tmo_cnt_r <= '0;
      rd_en_r   <= 1'b0;
      avg_vld_r <= 1'b0;
      timeout_r <= 1'b0;
      busy_o    <= 1'b0;
      avg_o     <= '0;
    end else if (en) begin
      rd_en_r   <= 1'b0;
      avg_vld_r <= 1'b0;
      timeout_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          acc_r     <= '0;
          smp_cnt_r <= '0;
          if (run) begin
            state_r <= S_WAIT_TICK;
            busy_o  <= 1'b1;
          end else begin
            busy_o  <= 1'b0;
          end
        end
        S_WAIT_TICK: begin
          if (!run) begin
            state_r   <= S_IDLE;
            busy_o    <= 1'b0;
            acc_r     <= '0;
            smp_cnt_r <= '0;
          end else if (tick_s) begin
            state_r <= S_REQ;
            rd_en_r <= 1'b1;
          end
        end
        S_REQ: begin
          tmo_cnt_r <= '0;
          state_r   <= S_WAIT_RDY;
        end
        S_WAIT_RDY: begin
          if (adc_rdy_i) begin
            acc_r     <= acc_r + ACC_W'(adc_data_i);
            smp_cnt_r <= smp_cnt_r + CNT_W'(1);
            state_r   <= S_ACC;
          end else if (tmo_cnt_r == TMO_LAST) begin
            timeout_r <= 1'b1;
            acc_r     <= '0;
            smp_cnt_r <= '0;
            state_r   <= S_WAIT_TICK;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        S_ACC: begin
          if (smp_cnt_r == N_SAMP) begin
            avg_o     <= acc_r[LOG2_N +: ADC_W];
            avg_vld_r <= 1'b1;
            acc_r     <= '0;
            smp_cnt_r <= '0;
            state_r   <= S_OUT;
          end else begin
            state_r   <= S_WAIT_TICK;
          end
        end
        S_OUT: begin
          if (run) begin
            state_r <= S_WAIT_TICK;
          end else begin
            state_r <= S_IDLE;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          busy_o    <= 1'b0;
          acc_r     <= '0;
          smp_cnt_r <= '0;
        end
      endcase
    end
  end

  assign rd_en_o   = rd_en_r & en;
  assign avg_vld_o = avg_vld_r & en;
  assign timeout_o = timeout_r & en;

`ifdef ADC_AVG_MINMAX_EN
  logic [ADC_W-1:0] win_min_r;
  logic [ADC_W-1:0] win_max_r;
  logic [ADC_W-1:0] seed_min_s;
  logic [ADC_W-1:0] seed_max_s;
  logic             capture_s;
  logic             publish_s;
  logic             expire_s;

  assign capture_s  = (state_r == S_WAIT_RDY) && adc_rdy_i;
  assign publish_s  = (state_r == S_ACC) && (smp_cnt_r == N_SAMP);
  assign expire_s   = (state_r == S_WAIT_RDY) && !adc_rdy_i && (tmo_cnt_r == TMO_LAST);
  assign seed_min_s = (smp_cnt_r == '0) ? {ADC_W{1'b1}} : win_min_r;
  assign seed_max_s = (smp_cnt_r == '0) ? {ADC_W{1'b0}} : win_max_r;

  // Window min/max trackers, published together with the mean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_min_r <= '0;
      win_max_r <= '0;
      min_o     <= '0;
      max_o     <= '0;
    end else if (en) begin
      if (capture_s) begin
        win_min_r <= min_of(seed_min_s, adc_data_i);
        win_max_r <= max_of(seed_max_s, adc_data_i);
      end else if (expire_s) begin
        win_min_r <= '0;
        win_max_r <= '0;
      end
      if (publish_s) begin
        min_o <= win_min_r;
        max_o <= win_max_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_avg_sched.sv
// Self-checking bench for adc_avg_sched with a 38-cycle socket model.
module tb_adc_avg_sched;

  localparam int PERIOD   = 50;
  localparam int LOG2_N   = 2;
  localparam int TIMEOUT  = 48;
  localparam int SOCK_LAT = 38;
  localparam int N        = 4;

  typedef struct packed { int s0; int s1; int s2; int s3; int avg; } vec_t;
  typedef struct packed { int avg; int mn; int mx; } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b1;
  logic        run = 1'b0;
  logic [11:0] adc_data_i = 12'd0;
  logic        adc_rdy_i = 1'b0;
  logic        rd_en_o, avg_vld_o, busy_o, timeout_o;
  logic [11:0] avg_o;
`ifdef ADC_AVG_MINMAX_EN
  logic [11:0] min_o, max_o;
`endif

  adc_avg_sched #(.PERIOD(PERIOD), .LOG2_N(LOG2_N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .run(run), .rd_en_o(rd_en_o),
    .adc_data_i(adc_data_i), .adc_rdy_i(adc_rdy_i), .avg_o(avg_o),
    .avg_vld_o(avg_vld_o), .busy_o(busy_o), .timeout_o(timeout_o)
`ifdef ADC_AVG_MINMAX_EN
    , .min_o(min_o), .max_o(max_o)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0, failures = 0;
  int   cyc = 0;
  int   rd_cnt = 0, vld_cnt = 0, tmo_cnt = 0, frz_bad = 0;
  int   last_rd = -1, vld_cyc = 0, tmo_cyc = 0;
  int   cd = 0, cur_data = 0, sock_v = 0;
  bit   chk_sp = 1'b0;
  int   sock_q[$];
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int evt_cnt(input int sel);
    case (sel)
      0:       return rd_cnt;
      1:       return vld_cnt;
      default: return tmo_cnt;
    endcase
  endfunction

  task automatic wait_evt(input int sel, input int budget, input string nm);
    int start, n;
    start = evt_cnt(sel);
    n = 0;
    while (evt_cnt(sel) == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(nm, evt_cnt(sel) - start, 1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue one window of socket replies and its expected mean/min/max.
  task automatic push_window(input int a, input int b, input int c, input int d, input int avg);
    int   w[4];
    exp_t e;
    w = '{a, b, c, d};
    e.avg = avg;
    e.mn = 4095;
    e.mx = 0;
    for (int i = 0; i < 4; i++) begin
      sock_q.push_back(w[i]);
      if (w[i] < e.mn) e.mn = w[i];
      if (w[i] > e.mx) e.mx = w[i];
    end
    exp_q.push_back(e);
  endtask

  // Socket model (replies SOCK_LAT enabled cycles after rd_en_o) and output monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      cd = 0;
      adc_rdy_i = 1'b0;
    end else if (en) begin
      adc_rdy_i = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          adc_rdy_i = 1'b1;
          adc_data_i = 12'(cur_data);
        end
      end
      if (rd_en_o) begin
        sock_v = (sock_q.size() > 0) ? sock_q.pop_front() : -1;
        if (sock_v >= 0) begin
          cd = SOCK_LAT;
          cur_data = sock_v;
        end
      end
    end
    if (!en && (rd_en_o || avg_vld_o || timeout_o)) frz_bad++;
    if (rd_en_o) begin
      rd_cnt++;
      if (chk_sp && last_rd >= 0) check("rd_spacing", cyc - last_rd, PERIOD);
      last_rd = cyc;
    end
    if (timeout_o) begin
      tmo_cnt++;
      tmo_cyc = cyc;
    end
    if (avg_vld_o) begin
      vld_cnt++;
      vld_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("avg_unexpected_vld", int'(avg_vld_o), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("avg", int'(avg_o), mon_e.avg);
`ifdef ADC_AVG_MINMAX_EN
        check("min", int'(min_o), mon_e.mn);
        check("max", int'(max_o), mon_e.mx);
`endif
      end
    end
  end

  initial begin
    int c, rd_before, vld_before, tmo_before;
    vecs[0] = '{s0: 100,  s1: 200,  s2: 300,  s3: 401,  avg: 250};
    vecs[1] = '{s0: 4095, s1: 4095, s2: 4095, s3: 4095, avg: 4095};
    vecs[2] = '{s0: 0,    s1: 0,    s2: 0,    s3: 3,    avg: 0};
    vecs[3] = '{s0: 1,    s1: 2,    s2: 3,    s3: 5,    avg: 2};
    vecs[4] = '{s0: 4095, s1: 4095, s2: 4095, s3: 4094, avg: 4094};
    vecs[5] = '{s0: 7,    s1: 7,    s2: 7,    s3: 7,    avg: 7};

    #1 rst_n = 1'b0;
    cycles(3);
    check("rst_avg_o", int'(avg_o), 0);
    check("rst_avg_vld_o", int'(avg_vld_o), 0);
    check("rst_busy_o", int'(busy_o), 0);
    check("rst_rd_en_o", int'(rd_en_o), 0);
    check("rst_timeout_o", int'(timeout_o), 0);
    rst_n = 1'b1;
    cycles(2);

    // Continuous run through the vector table; every request 50 cycles apart.
    chk_sp = 1'b1;
    c = cyc;
    for (int i = 0; i < 6; i++) begin
      push_window(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].avg);
      if (i == 0) run = 1'b1;
      wait_evt(1, N * PERIOD + 100, "vld_wait");
      if (i == 0) check("first_vld_latency", vld_cyc - c, N * PERIOD + SOCK_LAT + 3);
    end

    // Second request unanswered: timeout, then a clean window of 8s.
    sock_q.push_back(500);
    sock_q.push_back(-1);
    push_window(8, 8, 8, 8, 8);
    wait_evt(2, 200, "tmo_seen");
    check("tmo_delay", tmo_cyc - last_rd, TIMEOUT);
    check("avg_hold", int'(avg_o), vecs[5].avg);
    wait_evt(1, 6 * PERIOD + 100, "vld_after_tmo");
    chk_sp = 1'b0;

    // run drops while the third sample is in flight.
    sock_q.push_back(1000);
    sock_q.push_back(1000);
    sock_q.push_back(1000);
    for (int i = 0; i < 3; i++) wait_evt(0, PERIOD + 60, "rd_wait_drop");
    cycles(5);
    run = 1'b0;
    vld_before = vld_cnt;
    rd_before = rd_cnt;
    cycles(10);
    check("busy_in_wait_rdy", int'(busy_o), 1);
    cycles(60);
    check("busy_after_drop", int'(busy_o), 0);
    check("no_vld_after_drop", vld_cnt - vld_before, 0);
    cycles(60);
    check("no_rd_after_drop", rd_cnt - rd_before, 0);

    // en held low for 20 cycles inside WAIT_RDY: result shifted by exactly 20.
    push_window(100, 200, 300, 401, 250);
    c = cyc;
    tmo_before = tmo_cnt;
    run = 1'b1;
    wait_evt(0, PERIOD + 20, "rd_wait_frz");
    cycles(10);
    en = 1'b0;
    cycles(10);
    check("busy_frozen", int'(busy_o), 1);
    cycles(10);
    en = 1'b1;
    wait_evt(1, N * PERIOD + 100, "vld_wait_frz");
    check("vld_latency_frz", vld_cyc - c, N * PERIOD + SOCK_LAT + 3 + 20);
    check("frz_strobes", frz_bad, 0);
    check("frz_no_tmo", tmo_cnt - tmo_before, 0);

    // Reset asserted during ACC of the next window.
    sock_q.push_back(9);
    sock_q.push_back(9);
    sock_q.push_back(9);
    sock_q.push_back(9);
    wait_evt(0, PERIOD + 20, "rd_wait_rst");
    cycles(SOCK_LAT);
    rst_n = 1'b0;
    #1;
    check("rst_acc_avg_o", int'(avg_o), 0);
    check("rst_acc_busy_o", int'(busy_o), 0);
    check("rst_acc_rd_en_o", int'(rd_en_o), 0);
    check("rst_acc_vld_o", int'(avg_vld_o), 0);
    check("rst_acc_tmo_o", int'(timeout_o), 0);
    sock_q.delete();
    cycles(3);
    rst_n = 1'b1;
    c = cyc;
    cycles(2);
    check("busy_after_rst", int'(busy_o), 1);
    wait_evt(0, PERIOD + 20, "rd_after_rst");
    check("rd_after_rst_delay", last_rd - c, PERIOD + 1);
    run = 1'b0;
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
